// File: rtl/sim_mon_pkg.sv
// Shared types for the end-of-simulation monitor: FSM states, first-failure record and
// a lowest-set-bit helper used to pick the winning channel.
package sim_mon_pkg;

  localparam int MAX_CHAN   = 32;
  localparam int CHAN_IDX_W = 5;
  localparam int MAX_CODE_W = 32;
  localparam int MAX_CYC_W  = 64;

  typedef enum logic [1:0] {RUN, DRAIN_P, DRAIN_F, DONE} mon_state_t;

  // Sized for the largest legal configuration; the top trims fields to its parameters.
  typedef struct packed {
    logic [CHAN_IDX_W-1:0] chan;
    logic [MAX_CODE_W-1:0] code;
    logic                  is_timeout;
    logic [MAX_CYC_W-1:0]  cycle;
  } first_rec_t;

  function automatic logic [CHAN_IDX_W-1:0] lowest_set(input logic [MAX_CHAN-1:0] v);
    logic [CHAN_IDX_W-1:0] res;
    res = '0;
    for (int i = MAX_CHAN - 1; i >= 0; i--) begin
      if (v[i]) res = CHAN_IDX_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_mon_wdog.sv
// Single-channel watchdog: counts consecutive idle cycles and pulses timeout once on the
// limit-th idle cycle, then holds until progress, disable or a zero limit clears it.
module sim_mon_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              progress,
  input  logic              en,
  input  logic [WDOG_W-1:0] limit,
  output logic              timeout
);

  logic [WDOG_W-1:0] cnt;
  logic              clear;

  assign clear   = progress | ~en | (limit == '0);
  assign timeout = ~clear & (cnt == limit - WDOG_W'(1));

  // Stops at the limit so the timeout cannot fire twice without an intervening clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt < limit) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/sim_fail_monitor.sv
// Multi-channel end-of-simulation arbiter: records the first failure (channel, code,
// timestamp), counts a drain period after fail or pass, then raises done.
module sim_fail_monitor
  import sim_mon_pkg::*;
#(
  parameter int NUM_CHAN     = 4,
  parameter int CODE_W       = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int WDOG_W       = 16,
  parameter int CYC_W        = 32,
  parameter int CNT_W        = 8,
  localparam int CHAN_W      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CHAN-1:0]        fail_req,
  input  logic [NUM_CHAN*CODE_W-1:0] fail_code,
  input  logic [NUM_CHAN-1:0]        progress,
  input  logic [NUM_CHAN-1:0]        wdog_en,
  input  logic [WDOG_W-1:0]          wdog_limit,
  input  logic                       pass_req,
  output logic                       fail_flag,
  output logic                       pass_flag,
  output logic                       done,
  output logic [CHAN_W-1:0]          first_chan,
  output logic [CODE_W-1:0]          first_code,
  output logic                       first_is_timeout,
  output logic [CYC_W-1:0]           first_cycle,
  output logic [CNT_W-1:0]           fail_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int DLAST   = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  mon_state_t            state, state_n;
  first_rec_t            rec, rec_n, sel_rec;
  logic [DRAIN_W-1:0]    drain_cnt, drain_n;
  logic [CNT_W-1:0]      count_n;
  logic                  fail_n, pass_n, done_n;
  logic [CYC_W-1:0]      cyc;
  logic [NUM_CHAN-1:0]   timeout;
  logic [NUM_CHAN-1:0]   events;
  logic                  any_ev;
  logic [CHAN_IDX_W-1:0] sel_chan;
  logic [CODE_W-1:0]     sel_code;
  logic                  sel_is_to;

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_wdog
    sim_mon_wdog #(.WDOG_W(WDOG_W)) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .progress (progress[i]),
      .en       (wdog_en[i]),
      .limit    (wdog_limit),
      .timeout  (timeout[i])
    );
  end

  assign events   = fail_req | timeout;
  assign any_ev   = |events;
  assign sel_chan = lowest_set(MAX_CHAN'(events));

  // A fail request on the winning channel takes precedence over its own timeout.
  always_comb begin
    sel_code  = '0;
    sel_is_to = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (CHAN_IDX_W'(i) == sel_chan) begin
        sel_code  = fail_req[i] ? fail_code[i*CODE_W +: CODE_W] : '0;
        sel_is_to = ~fail_req[i];
      end
    end
    sel_rec            = '0;
    sel_rec.chan       = sel_chan;
    sel_rec.code       = MAX_CODE_W'(sel_code);
    sel_rec.is_timeout = sel_is_to;
    sel_rec.cycle      = MAX_CYC_W'(cyc);
  end

  always_comb begin
    state_n = state;
    rec_n   = rec;
    drain_n = drain_cnt;
    fail_n  = fail_flag;
    pass_n  = pass_flag;
    done_n  = done;
    count_n = fail_count;
    case (state)
      RUN: begin
        if (any_ev) begin
          rec_n   = sel_rec;
          fail_n  = 1'b1;
          state_n = DRAIN_F;
        end else if (pass_req) begin
          pass_n  = 1'b1;
          state_n = DRAIN_P;
        end
      end
      DRAIN_P: begin
        if (any_ev) begin
          rec_n   = sel_rec;
          pass_n  = 1'b0;
          fail_n  = 1'b1;
          state_n = DRAIN_F;
        end
      end
      default: ;
    endcase
    // Any transition into a drain state (re)starts the drain; a zero drain skips it.
    if (state_n != state && state_n != DONE) begin
      if (DRAIN_CYCLES == 0) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        drain_n = '0;
      end
    end else if (state == DRAIN_P || state == DRAIN_F) begin
      if (drain_cnt == DRAIN_W'(DLAST)) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        drain_n = drain_cnt + DRAIN_W'(1);
      end
    end
    if (state != DONE && any_ev && fail_count != {CNT_W{1'b1}}) begin
      count_n = fail_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      rec        <= '0;
      drain_cnt  <= '0;
      fail_flag  <= 1'b0;
      pass_flag  <= 1'b0;
      done       <= 1'b0;
      fail_count <= '0;
      cyc        <= '0;
    end else begin
      state      <= state_n;
      rec        <= rec_n;
      drain_cnt  <= drain_n;
      fail_flag  <= fail_n;
      pass_flag  <= pass_n;
      done       <= done_n;
      fail_count <= count_n;
      cyc        <= cyc + CYC_W'(1);
    end
  end

  assign first_chan       = rec.chan[CHAN_W-1:0];
  assign first_code       = rec.code[CODE_W-1:0];
  assign first_is_timeout = rec.is_timeout;
  assign first_cycle      = rec.cycle[CYC_W-1:0];

endmodule

// File: tb/tb_sim_fail_monitor.sv
// Directed bench for sim_fail_monitor: default drain, zero drain and long drain instances
// share one stimulus stream; expected values are hand-computed per cycle.
module tb_sim_fail_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fail_req;
  logic [31:0] fail_code;
  logic [3:0]  progress;
  logic [3:0]  wdog_en;
  logic [15:0] wdog_limit;
  logic        pass_req;

  logic        d_fail, d_pass, d_done, d_to;
  logic [1:0]  d_chan;
  logic [7:0]  d_code, d_count;
  logic [31:0] d_cycle;

  logic        z_fail, z_pass, z_done, z_to;
  logic [1:0]  z_chan;
  logic [7:0]  z_code, z_count;
  logic [31:0] z_cycle;

  logic        l_fail, l_pass, l_done, l_to;
  logic [1:0]  l_chan;
  logic [7:0]  l_code, l_count;
  logic [31:0] l_cycle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_fail_monitor dut (
    .clk(clk), .reset(reset), .fail_req(fail_req), .fail_code(fail_code),
    .progress(progress), .wdog_en(wdog_en), .wdog_limit(wdog_limit), .pass_req(pass_req),
    .fail_flag(d_fail), .pass_flag(d_pass), .done(d_done), .first_chan(d_chan),
    .first_code(d_code), .first_is_timeout(d_to), .first_cycle(d_cycle), .fail_count(d_count)
  );

  sim_fail_monitor #(.DRAIN_CYCLES(0)) dut_zero (
    .clk(clk), .reset(reset), .fail_req(fail_req), .fail_code(fail_code),
    .progress(progress), .wdog_en(wdog_en), .wdog_limit(wdog_limit), .pass_req(pass_req),
    .fail_flag(z_fail), .pass_flag(z_pass), .done(z_done), .first_chan(z_chan),
    .first_code(z_code), .first_is_timeout(z_to), .first_cycle(z_cycle), .fail_count(z_count)
  );

  sim_fail_monitor #(.DRAIN_CYCLES(400)) dut_long (
    .clk(clk), .reset(reset), .fail_req(fail_req), .fail_code(fail_code),
    .progress(progress), .wdog_en(wdog_en), .wdog_limit(wdog_limit), .pass_req(pass_req),
    .fail_flag(l_fail), .pass_flag(l_pass), .done(l_done), .first_chan(l_chan),
    .first_code(l_code), .first_is_timeout(l_to), .first_cycle(l_cycle), .fail_count(l_count)
  );

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] fr, input logic [31:0] code, input logic pr);
    fail_req  = fr;
    fail_code = code;
    pass_req  = pr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench #1 into cycle 0 with reset released.
  task automatic doReset();
    reset      = 1'b1;
    applyStimulus(4'b0, 32'h0, 1'b0);
    progress   = 4'b0;
    wdog_en    = 4'b0;
    wdog_limit = 16'd0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("rst_fail", d_fail, 0);
    checkOutput("rst_pass", d_pass, 0);
    checkOutput("rst_done", d_done, 0);
    checkOutput("rst_count", d_count, 0);
    checkOutput("rst_cycle", d_cycle, 0);

    // Single fail on ch2 at cycle 10.
    step(10);
    applyStimulus(4'b0100, 32'h005A_0000, 1'b0);
    step(1);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t1_fail", d_fail, 1);
    checkOutput("t1_done11", d_done, 0);
    checkOutput("t1_chan", d_chan, 2);
    checkOutput("t1_code", d_code, 8'h5A);
    checkOutput("t1_to", d_to, 0);
    checkOutput("t1_cycle", d_cycle, 10);
    checkOutput("t1_count", d_count, 1);
    checkOutput("t1_z_done", z_done, 1);
    step(1);
    checkOutput("t1_done12", d_done, 0);
    step(1);
    checkOutput("t1_done13", d_done, 1);

    // Two channels at once, then a later fail on ch0.
    doReset();
    step(3);
    applyStimulus(4'b1010, 32'h3300_1100, 1'b0);
    step(1);
    applyStimulus(4'b0001, 32'h0000_0077, 1'b0);
    step(1);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t2_chan", d_chan, 1);
    checkOutput("t2_code", d_code, 8'h11);
    checkOutput("t2_cycle", d_cycle, 3);
    checkOutput("t2_count", d_count, 2);
    checkOutput("t2_done", d_done, 0);

    // Pass at 5 converted by a fail at 6.
    doReset();
    step(5);
    applyStimulus(4'b0, 32'h0, 1'b1);
    step(1);
    checkOutput("t3_pass6", d_pass, 1);
    checkOutput("t3_fail6", d_fail, 0);
    checkOutput("t3_z_pass", z_pass, 1);
    checkOutput("t3_z_done", z_done, 1);
    applyStimulus(4'b1000, 32'hC300_0000, 1'b0);
    step(1);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t3_pass7", d_pass, 0);
    checkOutput("t3_fail7", d_fail, 1);
    checkOutput("t3_chan", d_chan, 3);
    checkOutput("t3_code", d_code, 8'hC3);
    checkOutput("t3_cycle", d_cycle, 6);
    checkOutput("t3_z_hold_pass", z_pass, 1);
    checkOutput("t3_z_hold_fail", z_fail, 0);
    step(1);
    checkOutput("t3_done8", d_done, 0);
    step(1);
    checkOutput("t3_done9", d_done, 1);

    // Watchdog timeout after 8 idle cycles starting at cycle 1.
    doReset();
    wdog_limit = 16'd8;
    step(1);
    wdog_en = 4'b0001;
    step(7);
    checkOutput("t4_fail8", d_fail, 0);
    step(1);
    checkOutput("t4_fail9", d_fail, 1);
    checkOutput("t4_to", d_to, 1);
    checkOutput("t4_code", d_code, 0);
    checkOutput("t4_chan", d_chan, 0);
    checkOutput("t4_cycle", d_cycle, 8);
    step(1);
    checkOutput("t4_count_once", d_count, 1);

    // Progress pulse at cycle 5 pushes the timeout to cycle 13.
    doReset();
    wdog_limit = 16'd8;
    step(1);
    wdog_en = 4'b0001;
    step(4);
    progress = 4'b0001;
    step(1);
    progress = 4'b0000;
    step(7);
    checkOutput("t5_fail13", d_fail, 0);
    step(1);
    checkOutput("t5_fail14", d_fail, 1);
    checkOutput("t5_cycle", d_cycle, 13);

    // Zero limit disables every watchdog.
    doReset();
    wdog_limit = 16'd0;
    wdog_en    = 4'hF;
    step(100);
    checkOutput("t6_fail", d_fail, 0);
    checkOutput("t6_count", d_count, 0);

    // Reset in the middle of the drain.
    doReset();
    step(2);
    applyStimulus(4'b0001, 32'h0000_0009, 1'b0);
    step(1);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t7_fail_pre", d_fail, 1);
    checkOutput("t7_code_pre", d_code, 8'h09);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("t7_fail", d_fail, 0);
    checkOutput("t7_code", d_code, 0);
    checkOutput("t7_cycle", d_cycle, 0);
    checkOutput("t7_count", d_count, 0);
    checkOutput("t7_done", d_done, 0);
    applyStimulus(4'b0, 32'h0, 1'b1);
    step(1);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t7_run_pass", d_pass, 1);

    // Continuous fail events: saturation on the long drain, freeze in DONE elsewhere.
    doReset();
    applyStimulus(4'b0001, 32'h0000_0001, 1'b0);
    step(200);
    checkOutput("t8_l_count200", l_count, 200);
    checkOutput("t8_d_frozen", d_count, 3);
    checkOutput("t8_z_frozen", z_count, 1);
    step(100);
    applyStimulus(4'b0, 32'h0, 1'b0);
    checkOutput("t8_l_sat", l_count, 255);
    checkOutput("t8_l_done", l_done, 0);
    checkOutput("t8_l_cycle", l_cycle, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_fail_monitor.md
Name: sim_fail_monitor

Overview:
- Parametrised multi-channel end-of-simulation arbiter: collects fail requests and per-channel watchdog timeouts from NUM_CHAN checkers, plus one pass request.
- Latches the first failure with its channel, code and timestamp, counts a programmable drain period, then asserts done for the bench top to call $finish.
- Sits beside the top-level monitor. It replaces the single global fail flag and fixed kill-wait count with a synthesizable, per-channel record.

Parameters:
- NUM_CHAN, 4, number of checker channels (1..32)
- CODE_W, 8, fail code width per channel
- DRAIN_CYCLES, 2, cycles from fail_flag/pass_flag rise to done rise (0 allowed)
- WDOG_W, 16, watchdog counter/limit width
- CYC_W, 32, free-running cycle timestamp width
- CNT_W, 8, fail event counter width

Ports:
- clk  in  1  simulation core clock
- reset  in  1  synchronous, active-high reset
- fail_req  in  NUM_CHAN  per-channel fail pulse
- fail_code  in  NUM_CHAN*CODE_W  channel i code at [i*CODE_W +: CODE_W], sampled with fail_req[i]
- progress  in  NUM_CHAN  per-channel forward-progress pulse (clears watchdog)
- wdog_en  in  NUM_CHAN  per-channel watchdog enable
- wdog_limit  in  WDOG_W  shared timeout threshold; 0 disables all watchdogs
- pass_req  in  1  global pass pulse
- fail_flag  out  1  a failure has been latched
- pass_flag  out  1  pass latched and no failure latched
- done  out  1  drain complete; bench finishes on its rise
- first_chan  out  max(1,$clog2(NUM_CHAN))  channel of first failure
- first_code  out  CODE_W  code of first failure (0 for timeout)
- first_is_timeout  out  1  first failure came from a watchdog
- first_cycle  out  CYC_W  cycle counter value when first failure was sampled
- fail_count  out  CNT_W  saturating count of failure events

Behaviour:
- Reset (sync, high): every output 0; cycle counter, watchdogs, drain counter 0; state RUN.
- Cycle counter: increments every non-reset cycle and wraps modulo 2^CYC_W. It keeps running in all states.
- Watchdog i: clears when progress[i]=1, when wdog_en[i]=0, or when wdog_limit=0. Otherwise it increments, saturating.
  - Timeout event i fires on the cycle the counter equals wdog_limit-1 and progress[i]=0, i.e. the limit-th consecutive idle cycle. It fires once, then the counter holds.
- Event i = fail_req[i] | timeout_i. On the same channel and cycle, fail_req wins (first_is_timeout=0).
- States:
  - RUN: on any event at cycle T, latch first_* using the lowest-index channel with first_cycle=counter@T. Set fail_flag at T+1 and go to DRAIN_F. Otherwise, pass_req at T sets pass_flag at T+1 and goes to DRAIN_P.
  - Same-cycle event and pass_req: the failure wins and the pass is ignored.
  - DRAIN_P: an event converts to a failure (latch first_*, pass_flag->0, fail_flag->1 next cycle) and restarts the drain in DRAIN_F. Further pass_req is ignored.
  - DRAIN_F: counts DRAIN_CYCLES; first_* is frozen and later events only bump fail_count.
  - DONE: done=1. All outputs hold until reset.
- Done timing: done rises exactly DRAIN_CYCLES cycles after fail_flag or pass_flag rises. With DRAIN_CYCLES=0, done rises with the flag and the state goes straight to DONE.
- fail_count: increments by 1 per cycle with at least one event, in RUN/DRAIN_P/DRAIN_F. It saturates at 2^CNT_W-1 and is frozen in DONE.
- Reset asserted mid-drain: returns to RUN immediately; all records are lost.

Decomposition:
- Package sim_mon_pkg: state enum (RUN, DRAIN_P, DRAIN_F, DONE), a first-failure record struct (chan, code, is_timeout, cycle), and a function for lowest-set-bit index.
- One sub-module, sim_mon_wdog: a single-channel watchdog counter with timeout pulse, instantiated NUM_CHAN times via generate.

Test Plan:
- fail_req=4'b0100 with code 0x5A at cycle 10 (defaults) -> fail_flag=1 at 11, done=1 at 13, first_chan=2, first_code=0x5A, first_cycle=10, fail_count=1.
- fail_req=4'b1010 at the same cycle -> first_chan=1. A later fail on ch0 leaves first_* unchanged and fail_count=2.
- pass_req at cycle 5, then fail_req[3] at cycle 6 -> pass_flag 6..6, fail_flag from 7, done at 9, first_chan=3.
- wdog_limit=8, wdog_en[0]=1, no progress from cycle 1 -> timeout on the 8th idle cycle, first_is_timeout=1, first_code=0. A progress pulse at cycle 5 instead delays the timeout by 5 cycles.
- wdog_limit=0 with long idle -> no timeout ever. pass_req with DRAIN_CYCLES=0 -> pass_flag and done rise in the same cycle.
- Reset asserted during DRAIN_F -> next cycle all outputs are 0 and state is RUN. 300 fail events -> fail_count saturates at 255.
